alu_seq_muldiv: RTL

//  Parametrised multi-cycle integer execute unit: single-cycle ALU ops plus iterative multiply (and optional divide).

---
 rtl/alu_seq_muldiv.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle integer execute unit.
// Single-cycle ALU ops (shifts, add/sub, logic, signed compares, LHI), an
// iterative radix-2 shift-add multiplier producing a 2*WIDTH product and,
// when the ALU_SEQ_DIV_EN macro is defined, an iterative restoring divider.
// Without ALU_SEQ_DIV_EN no divider logic is built and ops 18/19 are
// reported as unsupported. Results are registered and held under a
// valid/ready handshake so the core can stall on long operations.

module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             branch,
    output logic             err
);

    // Opcode map
    localparam logic [4:0] OP_SLL  = 5'd0;
    localparam logic [4:0] OP_SRL  = 5'd1;
    localparam logic [4:0] OP_SRA  = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_SEQ  = 5'd8;
    localparam logic [4:0] OP_SNE  = 5'd9;
    localparam logic [4:0] OP_SLT  = 5'd10;
    localparam logic [4:0] OP_SGT  = 5'd11;
    localparam logic [4:0] OP_SLE  = 5'd12;
    localparam logic [4:0] OP_SGE  = 5'd13;
    localparam logic [4:0] OP_LHI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_MULU = 5'd17;
    localparam logic [4:0] OP_DIV  = 5'd18;
    localparam logic [4:0] OP_DIVU = 5'd19;

    localparam logic [SHW-1:0] LAST_COUNT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic             accept;
    logic             last;
    logic [SHW-1:0]   count;

    // Single-cycle datapath results and op classification
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] alu_hi;
    logic             alu_err;
    logic             alu_iter;

    // Operand conditioning for the iterative ops
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Iteration state: acc_hi/acc_lo hold partial product or remainder/quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

`ifdef ALU_SEQ_DIV_EN
    logic             is_div;
    logic             neg_hi;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
`endif

    assign shamt = busB[SHW-1:0];

    // Combinational ALU: results for single-cycle ops, flags iterative ops
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_lo   = '0;
        alu_hi   = '0;
        alu_err  = 1'b0;
        alu_iter = 1'b0;
        case (op)
            OP_SLL:  alu_lo = busA << shamt;
            OP_SRL:  alu_lo = busA >> shamt;
            OP_SRA:  alu_lo = $signed(busA) >>> shamt;
            OP_ADD:  alu_lo = busA + busB;
            OP_SUB:  alu_lo = busA - busB;
            OP_OR:   alu_lo = busA | busB;
            OP_AND:  alu_lo = busA & busB;
            OP_XOR:  alu_lo = busA ^ busB;
            OP_SEQ:  alu_lo = WIDTH'(busA == busB);
            OP_SNE:  alu_lo = WIDTH'(busA != busB);
            OP_SLT:  alu_lo = WIDTH'($signed(busA) <  $signed(busB));
            OP_SGT:  alu_lo = WIDTH'($signed(busA) >  $signed(busB));
            OP_SLE:  alu_lo = WIDTH'($signed(busA) <= $signed(busB));
            OP_SGE:  alu_lo = WIDTH'($signed(busA) >= $signed(busB));
            OP_LHI:  alu_lo = busB;
            OP_MUL,
            OP_MULU: alu_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV,
            OP_DIVU: begin
                if (busB == '0) begin
                    // Divide-by-zero resolves immediately with a defined pattern
                    alu_lo  = '1;
                    alu_hi  = busA;
                    alu_err = 1'b1;
                end else begin
                    alu_iter = 1'b1;
                end
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // Signed iterative ops work on magnitudes; the sign is restored at the end
    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & busA[WIDTH-1];
        b_neg     = signed_op & busB[WIDTH-1];
        mag_a     = a_neg ? -busA : busA;
        mag_b     = b_neg ? -busB : busB;
    end

    // One iteration step: shift-add multiply, or restoring divide when enabled
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (is_div) begin
            // A borrow out of the trial subtraction means the divisor did not fit
            step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
            step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        end
`endif
    end

    // Sign fix-up of the final step: whole 2*WIDTH product, or quotient/remainder separately
    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_lo) begin
            prod = -prod;
        end
        fin_hi = prod[2*WIDTH-1:WIDTH];
        fin_lo = prod[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        if (is_div) begin
            fin_lo = neg_lo ? -step_lo : step_lo;
            fin_hi = neg_hi ? -step_hi : step_hi;
        end
`endif
    end

    // Handshake outputs and next-state selection
    always_comb begin
        in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid  = (state == DONE);
        accept     = in_valid && in_ready;
        last       = (state == BUSY) && (count == LAST_COUNT);
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = alu_iter ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = alu_iter ? BUSY : DONE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state, iteration counter and registered outputs
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            result    <= '0;
            result_hi <= '0;
            branch    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                count <= '0;
                if (!alu_iter) begin
                    result    <= alu_lo;
                    result_hi <= alu_hi;
                    branch    <= |alu_lo;
                    err       <= alu_err;
                end
            end else if (last) begin
                result    <= fin_lo;
                result_hi <= fin_hi;
                branch    <= |fin_lo;
                err       <= 1'b0;
            end else if (state == BUSY) begin
                count <= count + SHW'(1);
            end
        end
    end

    // Iteration datapath: loaded on accept of an iterative op, stepped while BUSY
    // NOTE: no reset here; these registers are always reloaded on accept before they are read.
    always_ff @(posedge clk) begin
        if (accept && alu_iter) begin
            acc_hi <= '0;
            neg_lo <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
            is_div <= op[1];
            neg_hi <= a_neg;
            if (op[1]) begin
                acc_lo <= mag_a;
                opnd   <= mag_b;
            end else begin
                acc_lo <= mag_b;
                opnd   <= mag_a;
            end
`else
            acc_lo <= mag_b;
            opnd   <= mag_a;
`endif
        end else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

endmodule
